mmul_array: RTL and testbench

Parametrised, multi-lane signed matrix multiplier computing the M×L product of an M×N matrix A and an N×L matrix B, with a start/busy/done handshake. It succeeds the single-MAC `mmul` block with the following changes:
- LANES parallel MAC lanes.
- A configurable accumulator width.
- A selectable saturating or wrapping output mode, with a sticky overflow flag.
- Operands latched on start, so upstream may change them while the block runs.

It sits between the operand-staging logic and the result consumer in the compute datapath.

---
 rtl/mmul_pkg.sv | 46 ++++
 rtl/mmul_mac_lane.sv | 33 +++
 rtl/mmul_array.sv | 183 ++++++++++++++++++
 tb/tb_mmul_array.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmul_pkg.sv
// Shared types and helpers for the multi-lane matrix multiplier.
package mmul_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [63:0] val;
        logic               ovf;
    } red_t;

    function automatic int clog2(input int v);
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) >= v) return r;
        end
        return 31;
    endfunction

    // Keeps vector and counter widths legal when a dimension is 0.
    function automatic int sz(input int v);
        return (v > 0) ? v : 1;
    endfunction

    function automatic red_t sat_reduce(
        input logic signed [63:0] acc,
        input int                 width,
        input logic               saturate
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        red_t               r;
        hi    = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo    = -hi - 64'sd1;
        r.ovf = (acc > hi) || (acc < lo);
        if (saturate && acc > hi)
            r.val = hi;
        else if (saturate && acc < lo)
            r.val = lo;
        else
            r.val = acc;
        return r;
    endfunction

endpackage

// File: rtl/mmul_mac_lane.sv
// One signed multiply-accumulate lane; acc is the post-update sum.
module mmul_mac_lane
    import mmul_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic                        clr,
    input  logic signed [WIDTH-1:0]     a,
    input  logic signed [WIDTH-1:0]     b,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] acc_q;

    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
    assign acc  = en ? acc_q + ACC_WIDTH'(prod) : acc_q;

    // Clear wins so the final sum is consumed and the next dot product starts at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc_q <= '0;
        else if (clr)
            acc_q <= '0;
        else if (en)
            acc_q <= acc;
    end

endmodule

// File: rtl/mmul_array.sv
// Multi-lane signed M x N by N x L matrix multiplier with start/busy/done.
module mmul_array
    import mmul_pkg::*;
#(
    parameter int M         = 2,
    parameter int N         = 2,
    parameter int L         = 2,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int LANES     = 1,
    parameter int SATURATE  = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [sz(M*N*WIDTH)-1:0]    mat_a,
    input  logic [sz(N*L*WIDTH)-1:0]    mat_b,
    output logic [sz(M*L*WIDTH)-1:0]    mat_axb,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow,
    output logic                        invalid
);

    localparam bit INV = (M == 0) || (N == 0) || (L == 0) || (LANES == 0)
                      || (LANES > L) || (ACC_WIDTH < 2*WIDTH);
    localparam int MS = sz(M);
    localparam int NS = sz(N);
    localparam int LS = sz(L);
    localparam int PS = sz(LANES);
    localparam int JB = (LS + PS - 1) / PS;
    localparam int IW = sz(clog2(MS));
    localparam int KW = sz(clog2(NS));
    localparam int BW = sz(clog2(JB));
    localparam int CW = sz(clog2(LS));
    localparam logic [IW-1:0] I_LAST = IW'(MS - 1);
    localparam logic [KW-1:0] K_LAST = KW'(NS - 1);
    localparam logic [BW-1:0] B_LAST = BW'(JB - 1);

    state_t                      state;
    logic [IW-1:0]               i_q;
    logic [BW-1:0]               jb_q;
    logic [KW-1:0]               k_q;
    logic signed [WIDTH-1:0]     a_in  [MS][NS];
    logic signed [WIDTH-1:0]     b_in  [NS][LS];
    logic signed [WIDTH-1:0]     a_q   [MS][NS];
    logic signed [WIDTH-1:0]     b_q   [NS][LS];
    logic signed [WIDTH-1:0]     res_q [MS][LS];
    logic signed [WIDTH-1:0]     res_d [MS][LS];
    logic [sz(M*L*WIDTH)-1:0]    res_flat;
    logic [sz(M*L*WIDTH)-1:0]    axb_q;
    logic                        done_q;
    logic                        ovf_q;
    logic                        ovf_any;
    logic                        run;
    logic                        k_last;
    logic                        jb_last;
    logic                        i_last;
    logic signed [ACC_WIDTH-1:0] acc [PS];
    logic                        act [PS];
    logic [CW-1:0]               col [PS];
    red_t                        red [PS];

    assign invalid  = INV;
    assign busy     = run;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign mat_axb  = axb_q;
    assign run      = (state == RUN);
    assign k_last   = (k_q == K_LAST);
    assign jb_last  = (jb_q == B_LAST);
    assign i_last   = (i_q == I_LAST);

    if (INV) begin : g_inv
        always_comb begin
            a_in     = '{default: '0};
            b_in     = '{default: '0};
            res_flat = '0;
        end
    end else begin : g_map
        for (genvar r = 0; r < M; r++) begin : g_a
            for (genvar c = 0; c < N; c++) begin : g_ac
                assign a_in[r][c] = mat_a[(r*N+c)*WIDTH +: WIDTH];
            end
        end
        for (genvar r = 0; r < N; r++) begin : g_b
            for (genvar c = 0; c < L; c++) begin : g_bc
                assign b_in[r][c] = mat_b[(r*L+c)*WIDTH +: WIDTH];
            end
        end
        for (genvar r = 0; r < M; r++) begin : g_o
            for (genvar c = 0; c < L; c++) begin : g_oc
                assign res_flat[(r*L+c)*WIDTH +: WIDTH] = res_d[r][c];
            end
        end
    end

    // Lanes past the last column of the final block sit idle.
    for (genvar p = 0; p < PS; p++) begin : g_lane
        logic [31:0] j;
        assign j      = 32'(jb_q) * 32'(PS) + 32'(p);
        assign act[p] = run && (j < 32'(LS));
        assign col[p] = act[p] ? CW'(j) : '0;
        assign red[p] = sat_reduce(64'(acc[p]), WIDTH, SATURATE != 0);

        mmul_mac_lane #(
            .WIDTH     (WIDTH),
            .ACC_WIDTH (ACC_WIDTH)
        ) u_mac (
            .clk   (clk),
            .reset (reset),
            .en    (act[p]),
            .clr   (act[p] && k_last),
            .a     (a_q[i_q][k_q]),
            .b     (b_q[k_q][col[p]]),
            .acc   (acc[p])
        );
    end

    always_comb begin
        res_d   = res_q;
        ovf_any = 1'b0;
        for (int p = 0; p < PS; p++) begin
            if (act[p] && k_last) begin
                res_d[i_q][col[p]] = WIDTH'(red[p].val);
                ovf_any            = ovf_any | red[p].ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            i_q    <= '0;
            jb_q   <= '0;
            k_q    <= '0;
            a_q    <= '{default: '0};
            b_q    <= '{default: '0};
            res_q  <= '{default: '0};
            axb_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && !INV) begin
                        state <= RUN;
                        i_q   <= '0;
                        jb_q  <= '0;
                        k_q   <= '0;
                        a_q   <= a_in;
                        b_q   <= b_in;
                        ovf_q <= 1'b0;
                    end
                end
                RUN: begin
                    res_q <= res_d;
                    ovf_q <= ovf_q | ovf_any;
                    if (!k_last) begin
                        k_q <= k_q + 1'b1;
                    end else begin
                        k_q <= '0;
                        if (!jb_last) begin
                            jb_q <= jb_q + 1'b1;
                        end else begin
                            jb_q <= '0;
                            if (!i_last) begin
                                i_q <= i_q + 1'b1;
                            end else begin
                                state  <= IDLE;
                                done_q <= 1'b1;
                                axb_q  <= res_flat;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmul_array.sv
// Directed-vector bench for mmul_array across several parameter sets.
module tb_mmul_array;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    localparam logic [31:0] A1  = {8'd4, 8'd3, 8'd2, 8'd1};
    localparam logic [31:0] B1  = {8'd8, 8'd7, 8'd6, 8'd5};
    localparam logic [31:0] R1  = {8'd50, 8'd43, 8'd22, 8'd19};
    localparam logic [31:0] A2  = {8'hFF, 8'h00, 8'h00, 8'hFF};
    localparam logic [31:0] R2  = {8'hF8, 8'hF9, 8'hFA, 8'hFB};
    localparam logic [31:0] AOV = {8'd0, 8'd0, 8'd0, 8'd100};
    localparam logic [31:0] ROV = {8'd0, 8'd0, 8'd0, 8'd16};
    localparam logic [47:0] MB  = {8'd3, 8'd1, 8'd0, 8'd2, 8'd0, 8'd1};
    localparam logic [47:0] RM  = {8'd18, 8'd4, 8'd3, 8'd8, 8'd2, 8'd1};

    logic [31:0] b_a, b_b, b_axb;
    logic        b_start, b_busy, b_done, b_ovf, b_inv;
    logic [7:0]  s_a, s_b, s_axb;
    logic        s_start, s_busy, s_done, s_ovf, s_inv;
    logic [7:0]  w_a, w_b, w_axb;
    logic        w_start, w_busy, w_done, w_ovf, w_inv;
    logic [31:0] m_a;
    logic [47:0] m_b, m_axb;
    logic        m_start, m_busy, m_done, m_ovf, m_inv;
    logic [0:0]  x_a, x_b;
    logic [31:0] x_axb;
    logic        x_start, x_busy, x_done, x_ovf, x_inv;

    mmul_array u_b (
        .clk(clk), .reset(reset), .start(b_start), .mat_a(b_a), .mat_b(b_b),
        .mat_axb(b_axb), .busy(b_busy), .done(b_done), .overflow(b_ovf),
        .invalid(b_inv)
    );

    mmul_array #(.M(1), .N(1), .L(1), .SATURATE(1)) u_s (
        .clk(clk), .reset(reset), .start(s_start), .mat_a(s_a), .mat_b(s_b),
        .mat_axb(s_axb), .busy(s_busy), .done(s_done), .overflow(s_ovf),
        .invalid(s_inv)
    );

    mmul_array #(.M(1), .N(1), .L(1), .SATURATE(0)) u_w (
        .clk(clk), .reset(reset), .start(w_start), .mat_a(w_a), .mat_b(w_b),
        .mat_axb(w_axb), .busy(w_busy), .done(w_done), .overflow(w_ovf),
        .invalid(w_inv)
    );

    mmul_array #(.M(2), .N(2), .L(3), .LANES(2)) u_m (
        .clk(clk), .reset(reset), .start(m_start), .mat_a(m_a), .mat_b(m_b),
        .mat_axb(m_axb), .busy(m_busy), .done(m_done), .overflow(m_ovf),
        .invalid(m_inv)
    );

    mmul_array #(.N(0)) u_x (
        .clk(clk), .reset(reset), .start(x_start), .mat_a(x_a), .mat_b(x_b),
        .mat_axb(x_axb), .busy(x_busy), .done(x_done), .overflow(x_ovf),
        .invalid(x_inv)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in cycle 1; returns the cycle done was seen, 0 on timeout.
    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        for (int c = 1; c <= 30; c++) begin
            if ((sel == 0 && b_done) || (sel == 1 && m_done)) begin
                cyc = c;
                break;
            end
            tick();
        end
    endtask

    int busy_cnt, done_cnt, done_cyc, cyc, seen;

    initial begin
        b_start = 0; s_start = 0; w_start = 0; m_start = 0; x_start = 0;
        b_a = '0; b_b = '0; s_a = '0; s_b = '0; w_a = '0; w_b = '0;
        m_a = '0; m_b = '0; x_a = '0; x_b = '0;

        tick();
        tick();
        chk("rst_busy", b_busy, 1'b0);
        chk("rst_done", b_done, 1'b0);
        chk("rst_axb", b_axb, 32'd0);
        chk("rst_ovf", b_ovf, 1'b0);
        chk("rst_inv", b_inv, 1'b0);
        chk("rst_m_busy", m_busy, 1'b0);
        chk("x_inv", x_inv, 1'b1);
        reset = 1'b0;
        tick();

        // Basic run, ignored starts at 3 and 5, re-start in the done cycle.
        b_a = A1; b_b = B1; b_start = 1'b1;
        tick();
        b_start = 1'b0; b_a = '1; b_b = '1;
        busy_cnt = 0; done_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 18; c++) begin
            if (b_busy) busy_cnt++;
            if (b_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == 1) chk("basic_busy1", b_busy, 1'b1);
            if (c == 9) begin
                chk("basic_done9", b_done, 1'b1);
                chk("basic_busy9", b_busy, 1'b0);
                chk("basic_axb", b_axb, R1);
                chk("basic_ovf", b_ovf, 1'b0);
                chk("basic_busy_cycles", busy_cnt, 8);
                chk("basic_done_first", done_cyc, 9);
            end
            if (c == 12) chk("hold_axb", b_axb, R1);
            if (c == 18) begin
                chk("b2b_done18", b_done, 1'b1);
                chk("b2b_axb", b_axb, R2);
                chk("b2b_done_cnt", done_cnt, 2);
            end
            b_start = (c == 3 || c == 5 || c == 9);
            if (c == 9) begin
                b_a = A2; b_b = B1;
            end else if (c == 10) begin
                b_a = '1; b_b = '1;
            end
            tick();
        end
        b_start = 1'b0;

        // Overflow on the 2x2 wrapping block.
        b_a = AOV; b_b = AOV; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_done(0, cyc);
        chk("ovf_lat", cyc, 9);
        chk("ovf_axb", b_axb, ROV);
        chk("ovf_flag", b_ovf, 1'b1);
        tick();

        // Reset at cycle 4 of a run.
        b_a = A1; b_b = B1; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("ovf_clr_start", b_ovf, 1'b0);
        tick(); tick(); tick();
        reset = 1'b1;
        #1;
        chk("midrst_busy", b_busy, 1'b0);
        chk("midrst_done", b_done, 1'b0);
        chk("midrst_axb", b_axb, 32'd0);
        chk("midrst_ovf", b_ovf, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        wait_done(0, cyc);
        chk("post_rst_lat", cyc, 9);
        chk("post_rst_axb", b_axb, R1);
        tick();

        // 1x1 saturate and wrap, positive then negative.
        s_a = 8'd100; s_b = 8'd100; w_a = 8'd100; w_b = 8'd100;
        s_start = 1'b1; w_start = 1'b1;
        tick();
        s_start = 1'b0; w_start = 1'b0;
        chk("sat_busy1", s_busy, 1'b1);
        tick();
        chk("sat_done", s_done, 1'b1);
        chk("sat_pos", s_axb, 8'd127);
        chk("sat_pos_ovf", s_ovf, 1'b1);
        chk("wrap_done", w_done, 1'b1);
        chk("wrap_pos", w_axb, 8'd16);
        chk("wrap_pos_ovf", w_ovf, 1'b1);
        tick();
        s_a = 8'h9C; w_a = 8'h9C;
        s_start = 1'b1; w_start = 1'b1;
        tick();
        s_start = 1'b0; w_start = 1'b0;
        tick();
        chk("sat_neg", s_axb, 8'h80);
        chk("sat_neg_ovf", s_ovf, 1'b1);
        chk("wrap_neg", w_axb, 8'hF0);
        chk("wrap_neg_ovf", w_ovf, 1'b1);

        // Two lanes over three columns; lane 1 of block 1 is masked.
        m_a = A1; m_b = MB; m_start = 1'b1;
        tick();
        m_start = 1'b0;
        wait_done(1, cyc);
        chk("mask_lat", cyc, 9);
        chk("mask_axb", m_axb, RM);
        chk("mask_ovf", m_ovf, 1'b0);

        // Illegal parameters never start.
        x_start = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (x_busy || x_done) seen = 1;
        end
        x_start = 1'b0;
        chk("inv_no_run", seen, 0);
        chk("inv_axb", x_axb, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
